router_in_port: RTL and testbench

- Router-side receiver for one endpoint link; directly downstream of the node's outbound byte-serial sender.
- Accepts 32-bit packets as 4 bytes over the put/free handshake, MSB byte first, and reassembles them.
- Buffers whole packets in a small FIFO and decodes the destination field into a one-hot output-port request.
- Holds each packet until the router crossbar/arbiter acknowledges it.

---
 rtl/router_in_port.sv | 175 +++++++++++++++++
 tb/tb_router_in_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_in_port.sv
`default_nettype none
// ============================================================================
//  Module   : router_in_port
//  Purpose  : Router-side receiver for one endpoint link. Reassembles 32-bit
//             packets sent as 4 bytes (MSB first) over the put/free
//             handshake, buffers whole packets in a small FIFO and decodes
//             the destination field of the head packet into a one-hot
//             output-port request held until the crossbar acknowledges it.
//  Ports    : clk             - rising-edge clock
//             rst_b           - asynchronous active-low reset
//             put_inbound     - payload_inbound carries a valid byte
//             payload_inbound - packet byte, order [31:24] .. [7:0]
//             free_inbound    - registered: a full packet may be started
//             pkt_out         - head-of-FIFO packet (combinational read)
//             pkt_valid       - FIFO non-empty
//             req             - one-hot output-port request of head packet
//             pkt_ack         - crossbar took the head packet (pop)
//             proto_err       - sticky protocol-error flag
//  Options  : ROUTER_IN_PROTO_CHECK_EN - when defined, put gaps inside a
//             packet abort it and puts without free set proto_err.
//             When undefined proto_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module router_in_port #(
   parameter int DEPTH     = 2,
   parameter int NUM_PORTS = 4,
   parameter int DEST_LSB  = 24,
   parameter int DEST_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 put_inbound,
   input  logic [7:0]           payload_inbound,
   output logic                 free_inbound,
   output logic [31:0]          pkt_out,
   output logic                 pkt_valid,
   output logic [NUM_PORTS-1:0] req,
   input  logic                 pkt_ack,
   output logic                 proto_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   logic [0:0]    state, state_nxt;
   logic [1:0]    bcnt, bcnt_nxt;
   logic [23:0]   shift, shift_nxt;
   logic          push;
   logic          pop;
   logic [31:0]   push_data;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic          free_nxt;
   logic [31:0]   mem [DEPTH];

`ifdef ROUTER_IN_PROTO_CHECK_EN
   logic          err_set;
   logic          err_r;
`endif

   // ------------------------------------------------------------------
   // Byte reassembly FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      bcnt_nxt  = bcnt;
      shift_nxt = shift;
      push      = 1'b0;
`ifdef ROUTER_IN_PROTO_CHECK_EN
      err_set   = 1'b0;
`endif
      case (state)
         ST_RECV: begin
            if (put_inbound) begin
               shift_nxt = {shift[15:0], payload_inbound};
               if (bcnt == 2'd3) begin
                  push      = 1'b1;
                  bcnt_nxt  = 2'd0;
                  state_nxt = ST_IDLE;
               end else begin
                  bcnt_nxt = bcnt + 2'd1;
               end
            end
`ifdef ROUTER_IN_PROTO_CHECK_EN
            else begin
               // A gap inside a packet discards the partial packet.
               bcnt_nxt  = 2'd0;
               state_nxt = ST_IDLE;
               err_set   = 1'b1;
            end
`endif
         end
         default: begin
            if (put_inbound && free_inbound) begin
               shift_nxt = {16'd0, payload_inbound};
               bcnt_nxt  = 2'd1;
               state_nxt = ST_RECV;
            end
`ifdef ROUTER_IN_PROTO_CHECK_EN
            else if (put_inbound) begin
               err_set = 1'b1;
            end
`endif
         end
      endcase
   end

   assign push_data = {shift, payload_inbound};

   // ------------------------------------------------------------------
   // FIFO bookkeeping. free_inbound reserves a slot before the first
   // byte, so a push never lands on a full FIFO.
   // ------------------------------------------------------------------
   assign pkt_valid = (count != '0);
   assign pop       = pkt_ack && pkt_valid;
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign free_nxt  = (state_nxt == ST_IDLE) && (count_nxt < CW'(DEPTH));
   assign pkt_out   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= ST_IDLE;
         bcnt         <= 2'd0;
         shift        <= 24'd0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         free_inbound <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'd0;
         end
      end else begin
         state        <= state_nxt;
         bcnt         <= bcnt_nxt;
         shift        <= shift_nxt;
         count        <= count_nxt;
         free_inbound <= free_nxt;
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Destination decode: out-of-range destinations match no port.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
      assign req[gi] = pkt_valid && (pkt_out[DEST_LSB +: DEST_W] == DEST_W'(gi));
   end

   // ------------------------------------------------------------------
   // Protocol error flag
   // ------------------------------------------------------------------
`ifdef ROUTER_IN_PROTO_CHECK_EN
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         err_r <= 1'b0;
      end else if (err_set) begin
         err_r <= 1'b1;
      end
   end
   assign proto_err = err_r;
`else
   assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_in_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_in_port
//  Purpose  : Self-checking bench for router_in_port. A queue-based packet
//             model predicts every output each cycle; directed sequences
//             pin the model with literal expectations, followed by random
//             put/ack traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_router_in_port;

   localparam int DEPTH = 2;
   localparam int NP    = 4;
   localparam int DL    = 24;
   localparam int DW    = 3;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic          put_inbound = 1'b0;
   logic [7:0]    payload_inbound = 8'd0;
   logic          pkt_ack = 1'b0;
   logic          free_inbound;
   logic [31:0]   pkt_out;
   logic          pkt_valid;
   logic [NP-1:0] req;
   logic          proto_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   router_in_port #(
      .DEPTH(DEPTH), .NUM_PORTS(NP), .DEST_LSB(DL), .DEST_W(DW)
   ) dut (
      .clk(clk), .rst_b(rst_b),
      .put_inbound(put_inbound), .payload_inbound(payload_inbound),
      .free_inbound(free_inbound),
      .pkt_out(pkt_out), .pkt_valid(pkt_valid), .req(req),
      .pkt_ack(pkt_ack), .proto_err(proto_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: stored packets, bytes of the packet in flight,
   // and the link-level free / error state.
   // ------------------------------------------------------------------
   logic [31:0] mq[$];
   logic [7:0]  bq[$];
   bit          mid_m  = 1'b0;
   bit          free_m = 1'b0;
   bit          err_m  = 1'b0;

   always @(posedge clk) begin
      if (!rst_b) begin
         mq.delete();
         bq.delete();
         mid_m  = 1'b0;
         free_m = 1'b0;
         err_m  = 1'b0;
      end else begin
         if (pkt_ack && mq.size() != 0) void'(mq.pop_front());
         if (!mid_m) begin
            if (put_inbound && free_m) begin
               bq.delete();
               bq.push_back(payload_inbound);
               mid_m = 1'b1;
            end
`ifdef ROUTER_IN_PROTO_CHECK_EN
            else if (put_inbound) err_m = 1'b1;
`endif
         end else if (put_inbound) begin
            bq.push_back(payload_inbound);
            if (bq.size() == 4) begin
               mq.push_back({bq[0], bq[1], bq[2], bq[3]});
               mid_m = 1'b0;
            end
         end
`ifdef ROUTER_IN_PROTO_CHECK_EN
         else begin
            mid_m = 1'b0;
            err_m = 1'b1;
         end
`endif
         free_m = !mid_m && (mq.size() < DEPTH);
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle comparison on the falling edge
   // ------------------------------------------------------------------
   logic [NP-1:0] exp_req;
   int            dest;

   always @(negedge clk) begin
      if (!rst_b) begin
         check("rst_free", free_inbound, 0);
         check("rst_valid", pkt_valid, 0);
         check("rst_pkt_out", pkt_out, 0);
         check("rst_req", req, 0);
         check("rst_proto_err", proto_err, 0);
      end else begin
         exp_req = '0;
         check("free", free_inbound, free_m);
         check("valid", pkt_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            check("pkt_out", pkt_out, mq[0]);
            dest = int'(mq[0][DL +: DW]);
            if (dest < NP) exp_req[dest] = 1'b1;
         end
         check("req", req, exp_req);
         check("proto_err", proto_err, err_m);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input logic [31:0] p);
      for (int i = 0; i < 4; i++) begin
         put_inbound     = 1'b1;
         payload_inbound = p[31-8*i -: 8];
         tick();
      end
      put_inbound = 1'b0;
   endtask

   task automatic wait_free();
      int n = 0;
      while (!free_inbound && n < 100) begin
         tick();
         n++;
      end
      if (!free_inbound) check("wait_free_timeout", free_inbound, 1);
   endtask

   task automatic ack_one();
      pkt_ack = 1'b1;
      tick();
      pkt_ack = 1'b0;
   endtask

   int          dl[5] = '{0, 1, 2, 3, 5};
   logic [3:0]  rl[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
   logic [31:0] p;

   initial begin
      // Reset and release
      repeat (3) tick();
      rst_b = 1'b1;
      check("free_at_release", free_inbound, 0);
      tick();
      check("free_rises", free_inbound, 1);

      // Basic packet, dest 1
      send_pkt(32'hA1B2C3D4);
      check("basic_pkt", pkt_out, 32'hA1B2C3D4);
      check("basic_valid", pkt_valid, 1);
      check("basic_req", req, 4'b0010);
      ack_one();
      check("basic_popped", pkt_valid, 0);

      // Fill both slots, third packet must be dropped
      send_pkt(32'h02AA0001);
      send_pkt(32'h03BB0002);
      check("full_free", free_inbound, 0);
      send_pkt(32'h01CC0003);
      check("full_head", pkt_out, 32'h02AA0001);
      ack_one();
      check("free_after_ack", free_inbound, 1);
      check("order_head", pkt_out, 32'h03BB0002);
      ack_one();
      check("fill_drained", pkt_valid, 0);

      // Push and pop on the same edge
      send_pkt(32'h00DD0004);
      p = 32'h01EE0005;
      for (int i = 0; i < 4; i++) begin
         put_inbound     = 1'b1;
         payload_inbound = p[31-8*i -: 8];
         pkt_ack         = (i == 3);
         tick();
      end
      put_inbound = 1'b0;
      pkt_ack     = 1'b0;
      check("same_edge_head", pkt_out, 32'h01EE0005);
      check("same_edge_valid", pkt_valid, 1);
      ack_one();
      check("same_edge_empty", pkt_valid, 0);

      // Reset in the middle of a packet
      put_inbound = 1'b1;
      payload_inbound = 8'h11;
      tick();
      payload_inbound = 8'h22;
      tick();
      put_inbound = 1'b0;
      rst_b = 1'b0;
      #1;
      check("midrst_free", free_inbound, 0);
      check("midrst_valid", pkt_valid, 0);
      check("midrst_pkt_out", pkt_out, 0);
      tick();
      tick();
      rst_b = 1'b1;
      wait_free();
      send_pkt(32'h55667788);
      check("post_rst_pkt", pkt_out, 32'h55667788);
      check("post_rst_req_dest5", req, 4'b0000);
      ack_one();

      // Put gap after the second byte
      wait_free();
      put_inbound = 1'b1;
      payload_inbound = 8'h02;
      tick();
      payload_inbound = 8'h77;
      tick();
      put_inbound = 1'b0;
      repeat (3) tick();
`ifdef ROUTER_IN_PROTO_CHECK_EN
      check("gap_proto_err", proto_err, 1);
      check("gap_nothing_pushed", pkt_valid, 0);
      check("gap_idle_free", free_inbound, 1);
`else
      put_inbound = 1'b1;
      payload_inbound = 8'h88;
      tick();
      payload_inbound = 8'h99;
      tick();
      put_inbound = 1'b0;
      check("gap_pkt", pkt_out, 32'h02778899);
      check("gap_req", req, 4'b0100);
      check("gap_no_err", proto_err, 0);
      ack_one();
`endif

      // Destination sweep
      for (int i = 0; i < 5; i++) begin
         wait_free();
         p = {5'd0, 3'(dl[i]), 24'h5A5A5A};
         send_pkt(p);
         check("sweep_valid", pkt_valid, 1);
         check("sweep_req", req, rl[i]);
         ack_one();
      end

      // Random traffic, with one asynchronous reset pulse
      for (int c = 0; c < 600; c++) begin
         put_inbound     = ($urandom_range(0, 3) != 0);
         payload_inbound = 8'($urandom);
         pkt_ack         = ($urandom_range(0, 2) == 0);
         if (c == 300) rst_b = 1'b0;
         if (c == 302) rst_b = 1'b1;
         tick();
      end
      put_inbound = 1'b0;
      pkt_ack     = 1'b1;
      repeat (6) tick();
      pkt_ack = 1'b0;
      tick();
      check("final_empty", pkt_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
